uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: 5..MAX_DATA_BITS data bits, optional parity,
// one or two stop bits, with frame, parity and break reporting.
`timescale 1ns/1ps
module uart_rx_cfg #(
   parameter int unsigned OVERSAMPLE    = 16,
   parameter int unsigned MAX_DATA_BITS = 9
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     rx_enabled,
   input  logic                     in,
   input  logic                     s_tick,
   input  logic [3:0]               cfg_data_bits,
   input  logic [1:0]               cfg_parity,
   input  logic                     cfg_stop2,
   output logic                     busy,
   output logic                     done,
   output logic                     frame_err,
   output logic                     parity_err,
   output logic                     break_det,
   output logic [MAX_DATA_BITS-1:0] out
);

   localparam int unsigned CntW = $clog2(OVERSAMPLE);
   localparam logic [CntW-1:0] CntMid = CntW'(OVERSAMPLE / 2 - 1);
   localparam logic [CntW-1:0] CntEnd = CntW'(OVERSAMPLE - 1);
   localparam logic [3:0] MaxBits = 4'(MAX_DATA_BITS);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StWaitIdle} state_e;

   state_e state_q, state_d;
   logic sync1_q, rx_s_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0] bit_idx_q, bit_idx_d;
   logic [3:0] nbits_q, nbits_d;
   logic [1:0] par_q, par_d;
   logic stop2_q, stop2_d;
   logic stop_idx_q, stop_idx_d;
   logic par_bit_q, par_bit_d;
   logic pe_cand_q, pe_cand_d;
   logic [MAX_DATA_BITS-1:0] data_q, data_d;
   logic [MAX_DATA_BITS-1:0] out_q, out_d;
   logic busy_q, busy_d, done_q, done_d, fe_q, fe_d, pe_q, pe_d, bd_q, bd_d;

   logic [3:0] nbits_cfg;
   logic par_en, sample_end, last_bit, par_xor;

   always_comb begin
      nbits_cfg = cfg_data_bits;
      if (cfg_data_bits < 4'd5) begin
         nbits_cfg = 4'd5;
      end else if (cfg_data_bits > MaxBits) begin
         nbits_cfg = MaxBits;
      end
   end

   assign par_en     = (par_q == 2'b01) || (par_q == 2'b10);
   assign sample_end = s_tick && (cnt_q == CntEnd);
   assign last_bit   = (bit_idx_q == nbits_q - 4'd1);
   assign par_xor    = (^data_q) ^ rx_s_q;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q    <= StIdle;
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         nbits_q    <= 4'd5;
         par_q      <= 2'b00;
         stop2_q    <= 1'b0;
         stop_idx_q <= 1'b0;
         par_bit_q  <= 1'b0;
         pe_cand_q  <= 1'b0;
         data_q     <= '0;
         out_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         fe_q       <= 1'b0;
         pe_q       <= 1'b0;
         bd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= in;
         rx_s_q     <= sync1_q;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         nbits_q    <= nbits_d;
         par_q      <= par_d;
         stop2_q    <= stop2_d;
         stop_idx_q <= stop_idx_d;
         par_bit_q  <= par_bit_d;
         pe_cand_q  <= pe_cand_d;
         data_q     <= data_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         fe_q       <= fe_d;
         pe_q       <= pe_d;
         bd_q       <= bd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (!rx_s_q && rx_enabled) state_d = StStart;
         StStart:    if (s_tick && cnt_q == CntMid) state_d = rx_s_q ? StIdle : StData;
         StData:     if (sample_end && last_bit) state_d = par_en ? StParity : StStop;
         StParity:   if (sample_end) state_d = StStop;
         StStop: begin
            if (sample_end) begin
               if (!rx_s_q) begin
                  state_d = StWaitIdle;
               end else if (!(stop2_q && !stop_idx_q)) begin
                  state_d = StIdle;
               end
            end
         end
         StWaitIdle: if (rx_s_q) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      nbits_d    = nbits_q;
      par_d      = par_q;
      stop2_d    = stop2_q;
      stop_idx_d = stop_idx_q;
      par_bit_d  = par_bit_q;
      pe_cand_d  = pe_cand_q;
      data_d     = data_q;
      out_d      = out_q;
      done_d     = 1'b0;
      fe_d       = 1'b0;
      pe_d       = 1'b0;
      bd_d       = 1'b0;
      busy_d     = (state_d != StIdle);
      unique case (state_q)
         StIdle: begin
            // Frame configuration is frozen here for the whole frame.
            if (!rx_s_q && rx_enabled) begin
               cnt_d      = '0;
               bit_idx_d  = '0;
               nbits_d    = nbits_cfg;
               par_d      = cfg_parity;
               stop2_d    = cfg_stop2;
               stop_idx_d = 1'b0;
               par_bit_d  = 1'b0;
               pe_cand_d  = 1'b0;
               data_d     = '0;
            end
         end
         StStart: begin
            if (s_tick) cnt_d = (cnt_q == CntMid) ? '0 : cnt_q + 1'b1;
         end
         StData: begin
            if (s_tick) cnt_d = (cnt_q == CntEnd) ? '0 : cnt_q + 1'b1;
            if (sample_end) begin
               for (int i = 0; i < int'(MAX_DATA_BITS); i++) begin
                  if (bit_idx_q == 4'(i)) data_d[i] = rx_s_q;
               end
               bit_idx_d = bit_idx_q + 4'd1;
            end
         end
         StParity: begin
            if (s_tick) cnt_d = (cnt_q == CntEnd) ? '0 : cnt_q + 1'b1;
            if (sample_end) begin
               par_bit_d = rx_s_q;
               pe_cand_d = (par_q == 2'b10) ? ~par_xor : par_xor;
            end
         end
         StStop: begin
            if (s_tick) cnt_d = (cnt_q == CntEnd) ? '0 : cnt_q + 1'b1;
            if (sample_end) begin
               if (!rx_s_q) begin
                  done_d = 1'b1;
                  out_d  = data_q;
                  fe_d   = 1'b1;
                  pe_d   = pe_cand_q;
                  // Break needs the first stop sample low as well as all data/parity bits.
                  bd_d   = !stop_idx_q && (data_q == '0) && !par_bit_q;
               end else if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  done_d = 1'b1;
                  out_d  = data_q;
                  pe_d   = pe_cand_q;
               end
            end
         end
         StWaitIdle: ;
         default: ;
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign frame_err  = fe_q;
   assign parity_err = pe_q;
   assign break_det  = bd_q;
   assign out        = out_q;

endmodule
